// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the two-port data memory arbiter.
// Optional round-robin arbitration is enabled by defining DMEM_ARB_RR_EN.
package dmem_arb_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int ADDR_W_DEF = 48;
  localparam int DEPTH_DEF  = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Requester identity: 0 = CPU path, 1 = loader/debug path
  typedef logic port_t;

  localparam port_t PORT0 = 1'b0;
  localparam port_t PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-way grant selector.
// DMEM_ARB_RR_EN defined: round-robin on contention; otherwise port 0 always wins.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic  valid0_i,
  input  logic  valid1_i,
`ifdef DMEM_ARB_RR_EN
  input  port_t last_grant_i,
`endif
  output logic  gnt_any_o,
  output port_t gnt_port_o
);

  assign gnt_any_o = valid0_i | valid1_i;

`ifdef DMEM_ARB_RR_EN
  // On contention hand the grant to whichever port did not win last time
  assign gnt_port_o = (valid0_i && valid1_i) ? port_t'(~last_grant_i) : port_t'(valid1_i);
`else
  assign gnt_port_o = port_t'(!valid0_i && valid1_i);
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the shared data memory: IDLE -> ACCESS -> RESP.
// Define DMEM_ARB_RR_EN for round-robin arbitration (default: fixed priority, port 0 wins).
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic              p0_req_we,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic              p1_req_we,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e            state_q, state_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  port_t             port_q;
  logic              err_q;

  logic              gnt_any;
  port_t             gnt_port;
  logic              can_grant;
  logic              grant;
  logic              in_range;
  logic              rsp0, rsp1;

`ifdef DMEM_ARB_RR_EN
  port_t             last_grant_q;
`endif

  dmem_arb_pick u_pick (
    .valid0_i     (p0_req_valid),
    .valid1_i     (p1_req_valid),
`ifdef DMEM_ARB_RR_EN
    .last_grant_i (last_grant_q),
`endif
    .gnt_any_o    (gnt_any),
    .gnt_port_o   (gnt_port)
  );

  // A new request may be taken while idle or while the previous response is out
  assign can_grant = (state_q == IDLE) || (state_q == RESP);
  assign grant     = can_grant && gnt_any && !rst;
  assign in_range  = (addr_q < ADDR_W'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = grant ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p0_req_ready   = grant && (gnt_port == PORT0);
    p1_req_ready   = grant && (gnt_port == PORT1);
    mem_write      = 1'b0;
    mem_read       = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    if (state_q == ACCESS) begin
      mem_write      = we_q && in_range;
      mem_read       = !we_q && in_range;
      mem_address    = addr_q;
      mem_write_data = wdata_q;
    end
    rsp0         = (state_q == RESP) && (port_q == PORT0);
    rsp1         = (state_q == RESP) && (port_q == PORT1);
    p0_rsp_valid = rsp0;
    p1_rsp_valid = rsp1;
    p0_rsp_err   = rsp0 && err_q;
    p1_rsp_err   = rsp1 && err_q;
    p0_rsp_rdata = rsp0 ? rdata_q : '0;
    p1_rsp_rdata = rsp1 ? rdata_q : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= PORT0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (grant) begin
        port_q  <= gnt_port;
        we_q    <= (gnt_port == PORT1) ? p1_req_we    : p0_req_we;
        addr_q  <= (gnt_port == PORT1) ? p1_req_addr  : p0_req_addr;
        wdata_q <= (gnt_port == PORT1) ? p1_req_wdata : p0_req_wdata;
      end
      if (state_q == ACCESS) begin
        err_q   <= !in_range;
        rdata_q <= (!we_q && in_range) ? mem_read_data : '0;
      end
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        last_grant_q <= PORT1;
    else if (grant) last_grant_q <= gnt_port;
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, contention/reset sequences, streaming and random traffic.
module tb_dmem_arbiter;

  logic        clk, rst;
  logic        p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid, p0_rsp_err;
  logic [47:0] p0_req_addr;
  logic [63:0] p0_req_wdata, p0_rsp_rdata;
  logic        p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid, p1_rsp_err;
  logic [47:0] p1_req_addr;
  logic [63:0] p1_req_wdata, p1_rsp_rdata;
  logic        mem_write, mem_read;
  logic [47:0] mem_address;
  logic [63:0] mem_write_data, mem_read_data;

  int checks = 0;
  int errors = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
    .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
    .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
    .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
    .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory stand-in: combinational read, write on rising edge
  logic [63:0] ram [64];
  always @(posedge clk) if (mem_write) ram[mem_address[5:0]] <= mem_write_data;
  assign mem_read_data = ram[mem_address[5:0]];

  // Reference contents: updated from the transactions the bench issues, not from the memory bus
  logic [63:0] exp_mem [64];

  // Requester must hold its fields stable while waiting for ready
  logic [112:0] f0_q, f1_q;
  logic         h0_q = 1'b0, h1_q = 1'b0;
  int           hold_viol = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (h0_q && p0_req_valid && ({p0_req_we, p0_req_addr, p0_req_wdata} != f0_q)) hold_viol <= hold_viol + 1;
      if (h1_q && p1_req_valid && ({p1_req_we, p1_req_addr, p1_req_wdata} != f1_q)) hold_viol <= hold_viol + 1;
    end
    h0_q <= p0_req_valid && !p0_req_ready;
    h1_q <= p1_req_valid && !p1_req_ready;
    f0_q <= {p0_req_we, p0_req_addr, p0_req_wdata};
    f1_q <= {p1_req_we, p1_req_addr, p1_req_wdata};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic we, input logic [47:0] a, input logic [63:0] d);
    if (p == 0) begin
      p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
    end else begin
      p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? p0_req_ready : p1_req_ready;
  endfunction

  task automatic reset_pulse();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  // One complete transaction: accept, ACCESS-cycle bus check, RESP-cycle response check
  task automatic xfer(input int p, input logic we, input logic [47:0] a, input logic [63:0] d,
                      input logic [63:0] er, input logic ee);
    int  n;
    logic inr;
    inr = (a < 48'd64);
    @(negedge clk);
    drive(p, 1'b1, we, a, d);
    #1;
    n = 0;
    while (!rdy(p) && n < 8) begin @(negedge clk); #1; n++; end
    chk("accept", {63'd0, rdy(p)}, 64'd1);
    @(posedge clk); #1;
    drive(p, 1'b0, 1'b0, 48'd0, 64'd0);
    @(negedge clk);
    chk("access_mem_write", {63'd0, mem_write}, {63'd0, we && inr});
    chk("access_mem_read", {63'd0, mem_read}, {63'd0, !we && inr});
    chk("access_mem_address", {16'd0, mem_address}, {16'd0, a});
    chk("access_mem_wdata", mem_write_data, d);
    @(negedge clk);
    chk("rsp_valid_own", {63'd0, (p == 0) ? p0_rsp_valid : p1_rsp_valid}, 64'd1);
    chk("rsp_valid_other", {63'd0, (p == 0) ? p1_rsp_valid : p0_rsp_valid}, 64'd0);
    chk("rsp_rdata", (p == 0) ? p0_rsp_rdata : p1_rsp_rdata, er);
    chk("rsp_err", {63'd0, (p == 0) ? p0_rsp_err : p1_rsp_err}, {63'd0, ee});
  endtask

  typedef struct {
    int          p;
    logic        we;
    logic [47:0] a;
    logic [63:0] d;
    logic [63:0] er;
    logic        ee;
  } vec_t;

  vec_t tv [12];

  initial begin
    int          n, rr, exp_port;
    logic        we;
    logic [47:0] a;
    logic [63:0] d, er;

    rr = 0;
`ifdef DMEM_ARB_RR_EN
    rr = 1;
`endif

    tv[0]  = '{0, 1'b1, 48'd5,              64'hDEADBEEF,         64'd0,                1'b0};
    tv[1]  = '{0, 1'b0, 48'd5,              64'd0,                64'hDEADBEEF,         1'b0};
    tv[2]  = '{1, 1'b0, 48'd64,             64'd0,                64'd0,                1'b1};
    tv[3]  = '{1, 1'b1, 48'd64,             64'hFF,               64'd0,                1'b1};
    tv[4]  = '{1, 1'b0, 48'd5,              64'd0,                64'hDEADBEEF,         1'b0};
    tv[5]  = '{1, 1'b1, 48'd63,             64'h0123456789ABCDEF, 64'd0,                1'b0};
    tv[6]  = '{0, 1'b0, 48'd63,             64'd0,                64'h0123456789ABCDEF, 1'b0};
    tv[7]  = '{0, 1'b0, 48'h1000_0000_0005, 64'd0,                64'd0,                1'b1};
    tv[8]  = '{0, 1'b1, 48'd0,              64'hAAAA5555,         64'd0,                1'b0};
    tv[9]  = '{1, 1'b0, 48'd0,              64'd0,                64'hAAAA5555,         1'b0};
    tv[10] = '{0, 1'b1, 48'h8000_0000_0005, 64'd1,                64'd0,                1'b1};
    tv[11] = '{0, 1'b0, 48'd5,              64'd0,                64'hDEADBEEF,         1'b0};

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 48'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 48'd0, 64'd0);
    @(negedge clk);
    p0_req_valid = 1'b1;
    #1;
    chk("reset_p0_ready", {63'd0, p0_req_ready}, 64'd0);
    chk("reset_rsp_valid", {62'd0, p0_rsp_valid, p1_rsp_valid}, 64'd0);
    chk("reset_rsp_err", {62'd0, p0_rsp_err, p1_rsp_err}, 64'd0);
    chk("reset_mem_strobes", {62'd0, mem_write, mem_read}, 64'd0);
    chk("reset_mem_address", {16'd0, mem_address}, 64'd0);
    chk("reset_mem_wdata", mem_write_data, 64'd0);
    p0_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      xfer(tv[i].p, tv[i].we, tv[i].a, tv[i].d, tv[i].er, tv[i].ee);
      if (tv[i].we && tv[i].a < 48'd64) exp_mem[tv[i].a[5:0]] = tv[i].d;
    end

    // Simultaneous requests after reset: port 0 first, port 1 taken in port 0's response cycle
    reset_pulse();
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 48'd5, 64'd0);
    drive(1, 1'b1, 1'b0, 48'd63, 64'd0);
    #1;
    chk("contend_p0_ready", {63'd0, p0_req_ready}, 64'd1);
    chk("contend_p1_ready", {63'd0, p1_req_ready}, 64'd0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 48'd0, 64'd0);
    @(negedge clk);
    chk("contend_p1_wait_access", {63'd0, p1_req_ready}, 64'd0);
    @(negedge clk);
    chk("contend_p0_rsp", {63'd0, p0_rsp_valid}, 64'd1);
    chk("contend_p0_rdata", p0_rsp_rdata, exp_mem[5]);
    chk("contend_p1_ready_in_resp", {63'd0, p1_req_ready}, 64'd1);
    @(posedge clk); #1;
    drive(1, 1'b0, 1'b0, 48'd0, 64'd0);
    @(negedge clk);
    @(negedge clk);
    chk("contend_p1_rsp", {63'd0, p1_rsp_valid}, 64'd1);
    chk("contend_p1_rdata", p1_rsp_rdata, exp_mem[63]);

    // Both ports held valid across 8 grants
    reset_pulse();
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 48'd3, 64'd0);
    drive(1, 1'b1, 1'b0, 48'd4, 64'd0);
    #1;
    for (int g = 0; g < 8; g++) begin
      n = 0;
      while (!(p0_req_ready || p1_req_ready) && n < 6) begin @(negedge clk); #1; n++; end
      exp_port = (rr != 0) ? (g % 2) : 0;
      chk("hold_grant_seen", {63'd0, p0_req_ready || p1_req_ready}, 64'd1);
      chk("hold_single_grant", {63'd0, p0_req_ready && p1_req_ready}, 64'd0);
      chk("hold_grant_port", {63'd0, p1_req_ready}, 64'(exp_port));
      chk("hold_grant_spacing", 64'(n), (g == 0) ? 64'd0 : 64'd1);
      @(negedge clk); #1;
    end
    drive(0, 1'b0, 1'b0, 48'd0, 64'd0);
    drive(1, 1'b0, 1'b0, 48'd0, 64'd0);
    @(negedge clk);
    @(negedge clk);

    // Reset during the ACCESS cycle of a store: nothing written, no response
    xfer(0, 1'b1, 48'd7, 64'h77, 64'd0, 1'b0);
    exp_mem[7] = 64'h77;
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 48'd7, 64'hBAD);
    #1;
    chk("rst_store_accept", {63'd0, p0_req_ready}, 64'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 48'd0, 64'd0);
    chk("rst_store_in_access", {63'd0, mem_write}, 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {62'd0, mem_write, mem_read}, 64'd0);
    chk("rst_mid_address", {16'd0, mem_address}, 64'd0);
    chk("rst_mid_wdata", mem_write_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_rsp", {62'd0, p0_rsp_valid, p1_rsp_valid}, 64'd0);
    end
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 48'd7, 64'd0);
    #1;
    chk("rst_fsm_idle_grant", {63'd0, p0_req_ready}, 64'd1);
    drive(0, 1'b0, 1'b0, 48'd0, 64'd0);
    xfer(0, 1'b0, 48'd7, 64'd0, 64'h77, 1'b0);

    // Preload every word, then stream port-1 loads back to back
    for (int i = 0; i < 64; i++) begin
      d = {$urandom, $urandom};
      xfer(i % 2, 1'b1, 48'(i), d, 64'd0, 1'b0);
      exp_mem[i] = d;
    end
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 48'd0, 64'd0);
    #1;
    for (int i = 0; i < 64; i++) begin
      n = 0;
      while (!p1_req_ready && n < 6) begin @(negedge clk); #1; n++; end
      chk("stream_accept", {63'd0, p1_req_ready}, 64'd1);
      chk("stream_spacing", 64'(n), (i == 0) ? 64'd0 : 64'd1);
      if (i > 0) begin
        chk("stream_rsp_valid", {63'd0, p1_rsp_valid}, 64'd1);
        chk("stream_rdata", p1_rsp_rdata, exp_mem[i-1]);
      end
      @(posedge clk); #1;
      if (i == 63) drive(1, 1'b0, 1'b0, 48'd0, 64'd0);
      else         drive(1, 1'b1, 1'b0, 48'(i + 1), 64'd0);
      @(negedge clk); #1;
      chk("stream_mem_read", {63'd0, mem_read}, 64'd1);
      chk("stream_mem_address", {16'd0, mem_address}, 64'(i));
    end
    @(negedge clk); #1;
    chk("stream_last_rsp", {63'd0, p1_rsp_valid}, 64'd1);
    chk("stream_last_rdata", p1_rsp_rdata, exp_mem[63]);

    // Random single transactions against the reference contents
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 9) == 0) ? {16'($urandom), 32'($urandom)} : 48'($urandom_range(0, 71));
      d  = {$urandom, $urandom};
      er = (!we && a < 48'd64) ? exp_mem[a[5:0]] : 64'd0;
      xfer(int'($urandom_range(0, 1)), we, a, d, er, a >= 48'd64);
      if (we && a < 48'd64) exp_mem[a[5:0]] = d;
    end

    chk("hold_stable_violations", 64'(hold_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
